// File: rtl/pulse_window_sequencer.sv
// Free-running window counter with start/stop/burst sequencing and a shadowed config port.
// f is driven low while lo_start <= count < lo_end; new config takes effect only at a period boundary.
module pulse_window_sequencer #(
    parameter int CNT_W        = 9,
    parameter int DEF_PERIOD   = 500,
    parameter int DEF_LO_START = 20,
    parameter int DEF_LO_END   = 90
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_lo_start,
    input  logic [CNT_W-1:0] cfg_lo_end,
    output logic             cfg_err,
    input  logic             start,
    input  logic             oneshot,
    input  logic [7:0]       burst_len,
    input  logic             stop,
    output logic             busy,
    output logic [CNT_W-1:0] count,
    output logic             period_done,
    output logic             f
);

    localparam logic [CNT_W-1:0] DEF_PERIOD_V   = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] DEF_LO_START_V = CNT_W'(DEF_LO_START);
    localparam logic [CNT_W-1:0] DEF_LO_END_V   = CNT_W'(DEF_LO_END);
    localparam logic [CNT_W-1:0] ONE_V          = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_V          = CNT_W'(2);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Active configuration driving the waveform
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] lo_start_q, lo_start_d;
    logic [CNT_W-1:0] lo_end_q, lo_end_d;

    // Shadow configuration waiting for a period boundary
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_lo_start_q, sh_lo_start_d;
    logic [CNT_W-1:0] sh_lo_end_q, sh_lo_end_d;
    logic             pending_q, pending_d;
    logic             cfg_err_q, cfg_err_d;

    logic             oneshot_q, oneshot_d;
    logic [7:0]       burst_target_q, burst_target_d;
    logic [7:0]       burst_cnt_q, burst_cnt_d;

    logic running;
    logic at_last;
    logic wrap;
    logic in_window;
    logic cfg_fire;
    logic cfg_ok;
    logic apply_cfg;
    logic burst_last;

    always_comb begin
        running   = (state_q != ST_IDLE);
        at_last   = (count_q == (period_q - ONE_V));
        wrap      = running && at_last;
        in_window = (count_q >= lo_start_q) && (count_q < lo_end_q);

        busy        = running;
        count       = count_q;
        period_done = wrap;
        f           = !(running && in_window);
        cfg_ready   = !pending_q;
        cfg_err     = cfg_err_q;
    end

    // Config handshake: validate on transfer, hold in shadow until it can be applied
    always_comb begin
        cfg_fire = cfg_valid && !pending_q;
        cfg_ok   = (cfg_period >= TWO_V) &&
                   (cfg_lo_start <= cfg_lo_end) &&
                   (cfg_lo_end <= cfg_period);

        // In IDLE the copy happens immediately; while running only at the wrap edge
        apply_cfg = pending_q && (!running || wrap);

        sh_period_d   = sh_period_q;
        sh_lo_start_d = sh_lo_start_q;
        sh_lo_end_d   = sh_lo_end_q;
        pending_d     = pending_q;
        period_d      = period_q;
        lo_start_d    = lo_start_q;
        lo_end_d      = lo_end_q;
        cfg_err_d     = cfg_fire && !cfg_ok;

        if (apply_cfg) begin
            period_d   = sh_period_q;
            lo_start_d = sh_lo_start_q;
            lo_end_d   = sh_lo_end_q;
            pending_d  = 1'b0;
        end

        // A transfer can only occur while nothing is pending, so it never races the copy
        if (cfg_fire && cfg_ok) begin
            sh_period_d   = cfg_period;
            sh_lo_start_d = cfg_lo_start;
            sh_lo_end_d   = cfg_lo_end;
            pending_d     = 1'b1;
        end
    end

    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        oneshot_d      = oneshot_q;
        burst_target_d = burst_target_q;
        burst_cnt_d    = burst_cnt_q;
        burst_last     = oneshot_q && (burst_cnt_q == (burst_target_q - 8'd1));

        unique case (state_q)
            ST_IDLE: begin
                count_d = '0;
                if (start && !stop) begin
                    state_d        = ST_RUN;
                    oneshot_d      = oneshot;
                    burst_target_d = (burst_len == 8'd0) ? 8'd1 : burst_len;
                    burst_cnt_d    = 8'd0;
                end
            end
            ST_RUN: begin
                if (at_last) begin
                    count_d = '0;
                    // A stop arriving on the last count of a period has nothing left to finish
                    if (stop || burst_last) begin
                        state_d = ST_IDLE;
                    end else if (oneshot_q) begin
                        burst_cnt_d = burst_cnt_q + 8'd1;
                    end
                end else begin
                    count_d = count_q + ONE_V;
                    if (stop) begin
                        state_d = ST_STOPPING;
                    end
                end
            end
            ST_STOPPING: begin
                if (at_last) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else begin
                    count_d = count_q + ONE_V;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            count_q        <= '0;
            period_q       <= DEF_PERIOD_V;
            lo_start_q     <= DEF_LO_START_V;
            lo_end_q       <= DEF_LO_END_V;
            sh_period_q    <= DEF_PERIOD_V;
            sh_lo_start_q  <= DEF_LO_START_V;
            sh_lo_end_q    <= DEF_LO_END_V;
            pending_q      <= 1'b0;
            cfg_err_q      <= 1'b0;
            oneshot_q      <= 1'b0;
            burst_target_q <= 8'd1;
            burst_cnt_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            count_q        <= count_d;
            period_q       <= period_d;
            lo_start_q     <= lo_start_d;
            lo_end_q       <= lo_end_d;
            sh_period_q    <= sh_period_d;
            sh_lo_start_q  <= sh_lo_start_d;
            sh_lo_end_q    <= sh_lo_end_d;
            pending_q      <= pending_d;
            cfg_err_q      <= cfg_err_d;
            oneshot_q      <= oneshot_d;
            burst_target_q <= burst_target_d;
            burst_cnt_q    <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_pulse_window_sequencer.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural
// model that tracks "periods left" and a stop request rather than an FSM.
module tb_pulse_window_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [8:0] cfg_period;
    logic [8:0] cfg_lo_start;
    logic [8:0] cfg_lo_end;
    logic       cfg_err;
    logic       start;
    logic       oneshot;
    logic [7:0] burst_len;
    logic       stop;
    logic       busy;
    logic [8:0] count;
    logic       period_done;
    logic       f;

    int checks   = 0;
    int failures = 0;

    // Behavioural model
    bit m_busy, m_stopping, m_pending, m_err, m_oneshot;
    int m_count, m_left;
    int m_per, m_ls, m_le;
    int s_per, s_ls, s_le;

    pulse_window_sequencer dut (
        .clock(clock), .reset(reset),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_period(cfg_period), .cfg_lo_start(cfg_lo_start), .cfg_lo_end(cfg_lo_end),
        .cfg_err(cfg_err), .start(start), .oneshot(oneshot), .burst_len(burst_len),
        .stop(stop), .busy(busy), .count(count), .period_done(period_done), .f(f)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        bit xfer, ok;
        if (reset) begin
            m_busy = 0; m_stopping = 0; m_pending = 0; m_err = 0; m_oneshot = 0;
            m_count = 0; m_left = 0;
            m_per = 500; m_ls = 20; m_le = 90;
            s_per = 500; s_ls = 20; s_le = 90;
            return;
        end
        xfer  = cfg_valid && !m_pending;
        ok    = (cfg_period >= 2) && (cfg_lo_start <= cfg_lo_end) && (cfg_lo_end <= cfg_period);
        m_err = xfer && !ok;
        if (!m_busy) begin
            if (m_pending) begin
                m_per = s_per; m_ls = s_ls; m_le = s_le; m_pending = 0;
            end
            if (start && !stop) begin
                m_busy = 1; m_stopping = 0; m_count = 0;
                m_oneshot = oneshot;
                m_left = (burst_len == 0) ? 1 : int'(burst_len);
            end
        end else if (m_count == m_per - 1) begin
            if (m_pending) begin
                m_per = s_per; m_ls = s_ls; m_le = s_le; m_pending = 0;
            end
            if (m_stopping || stop || (m_oneshot && m_left == 1)) m_busy = 0;
            else if (m_oneshot) m_left--;
            m_count = 0;
        end else begin
            m_count++;
            if (stop) m_stopping = 1;
        end
        if (xfer && ok) begin
            s_per = cfg_period; s_ls = cfg_lo_start; s_le = cfg_lo_end; m_pending = 1;
        end
    endtask

    task automatic compare_all();
        chk("count", int'(count), m_count);
        chk("busy", int'(busy), int'(m_busy));
        chk("f", int'(f), int'(!(m_busy && m_count >= m_ls && m_count < m_le)));
        chk("period_done", int'(period_done), int'(m_busy && m_count == m_per - 1));
        chk("cfg_ready", int'(cfg_ready), int'(!m_pending));
        chk("cfg_err", int'(cfg_err), int'(m_err));
    endtask

    task automatic cycle();
        @(posedge clock);
        model_step();
        @(negedge clock);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic idle_inputs();
        reset = 0; cfg_valid = 0; cfg_period = 0; cfg_lo_start = 0; cfg_lo_end = 0;
        start = 0; oneshot = 0; burst_len = 0; stop = 0;
    endtask

    task automatic send_cfg(input int p, input int ls, input int le);
        cfg_valid = 1; cfg_period = 9'(p); cfg_lo_start = 9'(ls); cfg_lo_end = 9'(le);
        cycle();
        cfg_valid = 0;
    endtask

    task automatic do_start(input bit os, input int bl);
        start = 1; oneshot = os; burst_len = 8'(bl);
        cycle();
        start = 0; oneshot = 0; burst_len = 0;
    endtask

    task automatic wait_idle(input string name, input int limit, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < limit) begin
            cycle();
            n++;
        end
        chk(name, n, exp_cycles);
    endtask

    initial begin
        int pulses;
        int n;
        idle_inputs();
        reset = 1;
        run(3);
        reset = 0;
        cycle();
        chk("rst_count", int'(count), 0);
        chk("rst_f", int'(f), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_ready", int'(cfg_ready), 1);
        chk("rst_pd", int'(period_done), 0);

        // T1: continuous run with the default window
        do_start(0, 0);
        chk("t1_first_count", int'(count), 0);
        run(19);  chk("t1_f19", int'(f), 1);
        run(1);   chk("t1_f20", int'(f), 0);
        run(69);  chk("t1_f89", int'(f), 0);
        run(1);   chk("t1_f90", int'(f), 1);
        run(409); chk("t1_pd499", int'(period_done), 1);
        run(1);   chk("t1_wrap", int'(count), 0);

        // T2: config lands at count 100, applied only after the wrap
        run(100);
        send_cfg(10, 2, 5);
        chk("t2_ready_lo", int'(cfg_ready), 0);
        run(398); chk("t2_count499", int'(count), 499);
        chk("t2_ready_still_lo", int'(cfg_ready), 0);
        run(1);   chk("t2_ready_hi", int'(cfg_ready), 1);
        run(2);   chk("t2_f2", int'(f), 0);
        run(3);   chk("t2_f5", int'(f), 1);
        run(4);   chk("t2_pd9", int'(period_done), 1);

        // T3: rejected config
        send_cfg(50, 10, 60);
        chk("t3_err", int'(cfg_err), 1);
        chk("t3_ready", int'(cfg_ready), 1);
        run(1);   chk("t3_err_clear", int'(cfg_err), 0);
        run(25);

        stop = 1; cycle(); stop = 0;
        wait_idle("stop_short", 20, int'(count == 0 && !busy ? 0 : 0) + n_left_short());
        send_cfg(500, 20, 90);
        run(2);

        // T4: three-period burst
        do_start(1, 3);
        n = 0; pulses = 0;
        while (busy && n < 2000) begin
            cycle();
            n++;
            if (period_done) pulses++;
        end
        chk("t4_cycles", n, 1500);
        chk("t4_pulses", pulses, 3);
        chk("t4_f_after", int'(f), 1);

        // T5: graceful stop, then start+stop in IDLE
        do_start(0, 0);
        run(100);
        stop = 1; cycle(); stop = 0;
        wait_idle("t5_stop_cycles", 600, 399);
        chk("t5_count", int'(count), 0);
        chk("t5_f", int'(f), 1);
        start = 1; stop = 1; cycle(); start = 0; stop = 0;
        chk("t5_start_stop_idle", int'(busy), 0);

        // T6: reset mid-run with a pending config
        do_start(0, 0);
        run(10);
        send_cfg(10, 2, 5);
        run(39);
        chk("t6_count50", int'(count), 50);
        reset = 1; cycle(); reset = 0;
        chk("t6_count", int'(count), 0);
        chk("t6_f", int'(f), 1);
        chk("t6_busy", int'(busy), 0);
        chk("t6_ready", int'(cfg_ready), 1);
        do_start(0, 0);
        run(20);
        chk("t6_def_window", int'(f), 0);
        run(15);

        // Random traffic with short periods
        send_cfg(12, 3, 7);
        for (int i = 0; i < 4000; i++) begin
            reset        = ($urandom_range(0, 999) == 0);
            start        = ($urandom_range(0, 7) == 0);
            stop         = ($urandom_range(0, 39) == 0);
            oneshot      = $urandom_range(0, 1) == 1;
            burst_len    = 8'($urandom_range(0, 3));
            cfg_valid    = ($urandom_range(0, 5) == 0);
            cfg_period   = 9'($urandom_range(0, 30));
            cfg_lo_start = 9'($urandom_range(0, 32));
            cfg_lo_end   = 9'($urandom_range(0, 32));
            cycle();
        end
        idle_inputs();
        run(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Cycles still needed to finish the current 10-cycle period after stop was registered
    function automatic int n_left_short();
        return (count == 0 && !busy) ? 0 : (9 - int'(count)) + 1;
    endfunction

endmodule
